// File: rtl/oai31_arc_stimulus_if.sv
// rtl/oai31_arc_stimulus_if.sv - controller/cell-side signals of the OAI31 arc stimulus sequencer
interface oai31_arc_stimulus_if;
    logic       start;
    logic       y;
    logic       a0;
    logic       a1;
    logic       a2;
    logic       b;
    logic       busy;
    logic       done;
    logic [5:0] err_cnt;
    logic [3:0] fail_arc;

    modport master (
        output start, y,
        input  a0, a1, a2, b, busy, done, err_cnt, fail_arc
    );

    modport slave (
        input  start, y,
        output a0, a1, a2, b, busy, done, err_cnt, fail_arc
    );
endinterface

// File: rtl/oai31_arc_stimulus.sv
// rtl/oai31_arc_stimulus.sv - walks an OAI31 cell through all 10 timing arcs and checks Y
module oai31_arc_stimulus #(
    parameter int unsigned HOLD = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    oai31_arc_stimulus_if.slave   cell_if
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_RISE,
        S_FALL,
        S_DONE
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t     state_q;
    logic [7:0] hold_q;
    logic [3:0] arc_q;
    logic [3:0] pins_q;
    logic       busy_q;
    logic       done_q;
    logic [5:0] err_q;
    logic [3:0] fail_q;
    logic       ys1_q;
    logic       ys2_q;

    logic       last_d;
    logic       exp_d;
    logic       mismatch_d;
    logic [3:0] arc_d;

    // {A0,A1,A2,B} for an arc with its toggled pin at value p
    function automatic logic [3:0] arc_vec(input logic [3:0] arc, input logic p);
        logic [3:0] v;
        case (arc)
            4'd0:    v = {p, 3'b001};
            4'd1:    v = {1'b0, p, 2'b01};
            4'd2:    v = {2'b00, p, 1'b1};
            4'd3:    v = {3'b111, p};
            4'd4:    v = {3'b110, p};
            4'd5:    v = {3'b101, p};
            4'd6:    v = {3'b011, p};
            4'd7:    v = {3'b100, p};
            4'd8:    v = {3'b010, p};
            4'd9:    v = {3'b001, p};
            default: v = 4'b0000;
        endcase
        return v;
    endfunction

    always_comb begin
        last_d     = (hold_q == HOLD_LAST);
        exp_d      = (state_q != S_RISE);
        mismatch_d = last_d && (ys2_q != exp_d) &&
                     ((state_q == S_SETUP) || (state_q == S_RISE) || (state_q == S_FALL));
        arc_d      = arc_q + 4'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            hold_q  <= 8'd0;
            arc_q   <= 4'd0;
            pins_q  <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 6'd0;
            fail_q  <= 4'hF;
            ys1_q   <= 1'b1;
            ys2_q   <= 1'b1;
        end else begin
            ys1_q <= cell_if.y;
            ys2_q <= ys1_q;
            if (mismatch_d) begin
                if (err_q != 6'd63) err_q <= err_q + 6'd1;
                if (fail_q == 4'hF) fail_q <= arc_q;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    hold_q <= 8'd0;
                    if (cell_if.start) begin
                        state_q <= S_SETUP;
                        arc_q   <= 4'd0;
                        pins_q  <= arc_vec(4'd0, 1'b0);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 6'd0;
                        fail_q  <= 4'hF;
                    end
                end
                S_SETUP: begin
                    if (last_d) begin
                        hold_q  <= 8'd0;
                        state_q <= S_RISE;
                        pins_q  <= arc_vec(arc_q, 1'b1);
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                S_RISE: begin
                    if (last_d) begin
                        hold_q  <= 8'd0;
                        state_q <= S_FALL;
                        pins_q  <= arc_vec(arc_q, 1'b0);
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                S_FALL: begin
                    if (last_d) begin
                        hold_q <= 8'd0;
                        if (arc_q == 4'd9) begin
                            state_q <= S_DONE;
                            pins_q  <= 4'b0000;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_SETUP;
                            arc_q   <= arc_d;
                            pins_q  <= arc_vec(arc_d, 1'b0);
                        end
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cell_if.a0       = pins_q[3];
    assign cell_if.a1       = pins_q[2];
    assign cell_if.a2       = pins_q[1];
    assign cell_if.b        = pins_q[0];
    assign cell_if.busy     = busy_q;
    assign cell_if.done     = done_q;
    assign cell_if.err_cnt  = err_q;
    assign cell_if.fail_arc = fail_q;
endmodule

// File: tb/tb_oai31_arc_stimulus.sv
// tb/tb_oai31_arc_stimulus.sv - directed bench for oai31_arc_stimulus at HOLD=4 and HOLD=3
module tb_oai31_arc_stimulus;
    logic clk;
    logic rst;
    logic start4, start3;
    int   m4, m3;
    int   checks = 0;
    int   errors = 0;

    oai31_arc_stimulus_if if4 ();
    oai31_arc_stimulus_if if3 ();

    oai31_arc_stimulus #(.HOLD(4)) u4 (.clk_i(clk), .rst_i(rst), .cell_if(if4));
    oai31_arc_stimulus #(.HOLD(3)) u3 (.clk_i(clk), .rst_i(rst), .cell_if(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cell models: 0 ideal, 1 tied 0, 2 ignores B, 3 settles inside 1 cycle, 4 settles inside 2 cycles
    logic y4_i, y4_d1, y4_d2, y3_i, y3_d1, y3_d2;
    assign y4_i = ~((if4.a0 | if4.a1 | if4.a2) & if4.b);
    assign y3_i = ~((if3.a0 | if3.a1 | if3.a2) & if3.b);
    assign #9  y4_d1 = y4_i;
    assign #19 y4_d2 = y4_i;
    assign #9  y3_d1 = y3_i;
    assign #19 y3_d2 = y3_i;

    function automatic logic model(input int mode, input logic a0, input logic a1,
                                   input logic a2, input logic yi, input logic d1, input logic d2);
        case (mode)
            1:       return 1'b0;
            2:       return ~(a0 | a1 | a2);
            3:       return d1;
            4:       return d2;
            default: return yi;
        endcase
    endfunction

    assign if4.y     = model(m4, if4.a0, if4.a1, if4.a2, y4_i, y4_d1, y4_d2);
    assign if3.y     = model(m3, if3.a0, if3.a1, if3.a2, y3_i, y3_d1, y3_d2);
    assign if4.start = start4;
    assign if3.start = start3;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic get_busy(input int u);
        return (u == 3) ? if3.busy : if4.busy;
    endfunction

    function automatic logic [3:0] get_pins(input int u);
        return (u == 3) ? {if3.a0, if3.a1, if3.a2, if3.b} : {if4.a0, if4.a1, if4.a2, if4.b};
    endfunction

    function automatic logic [11:0] get_res(input int u);
        return (u == 3) ? {1'b0, if3.done, if3.err_cnt, if3.fail_arc}
                        : {1'b0, if4.done, if4.err_cnt, if4.fail_arc};
    endfunction

    task automatic pulse_start(input int u);
        @(negedge clk);
        if (u == 3) start3 = 1'b1; else start4 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        start4 = 1'b0;
    endtask

    // Counts busy cycles from cycle 0 of a run; optionally re-pulses START and probes the pins
    task automatic run(input int u, input int inj, output int n,
                       output logic [3:0] pp, output logic py);
        n  = 0;
        pp = 4'h0;
        py = 1'b1;
        while (get_busy(u) && n < 2000) begin
            if (n == 64) begin
                pp = get_pins(u);
                py = (u == 3) ? if3.y : if4.y;
            end
            if (n == inj) begin
                if (u == 3) start3 = 1'b1; else start4 = 1'b1;
            end
            @(posedge clk);
            #1;
            start3 = 1'b0;
            start4 = 1'b0;
            n++;
        end
    endtask

    int         n;
    logic [3:0] pp;
    logic       py;

    initial begin
        rst    = 1'b0;
        start4 = 1'b0;
        start3 = 1'b0;
        m4     = 0;
        m3     = 0;
        #1 rst = 1'b1;
        #2;
        check("reset_pins", {28'd0, get_pins(4)}, 32'h0);
        check("reset_busy", {31'd0, get_busy(4)}, 32'h0);
        check("reset_res", {20'd0, get_res(4)}, {20'd0, 12'h00F});
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Ideal cell
        pulse_start(4);
        check("first_setup_pins", {28'd0, get_pins(4)}, 32'h1);
        check("first_busy", {31'd0, get_busy(4)}, 32'h1);
        run(4, -1, n, pp, py);
        check("ideal_len", n, 120);
        check("arc5_rise_pins", {28'd0, pp}, 32'hB);
        check("arc5_rise_y", {31'd0, py}, 32'h0);
        check("ideal_res", {20'd0, get_res(4)}, {20'd0, 12'h40F});
        check("done_pins", {28'd0, get_pins(4)}, 32'h0);

        // Y tied low
        m4 = 1;
        pulse_start(4);
        run(4, -1, n, pp, py);
        check("tie0_len", n, 120);
        check("tie0_res", {20'd0, get_res(4)}, {20'd0, 12'h400 | (12'd20 << 4) | 12'd0});

        // Cell ignoring B
        m4 = 2;
        pulse_start(4);
        run(4, -1, n, pp, py);
        check("nob_res", {20'd0, get_res(4)}, {20'd0, 12'h400 | (12'd14 << 4) | 12'd3});

        // Reset mid-run
        m4 = 1;
        pulse_start(4);
        repeat (50) begin
            @(posedge clk);
            #1;
        end
        check("midrun_err", {26'd0, if4.err_cnt}, 32'd8);
        #2 rst = 1'b1;
        #1;
        check("abort_pins", {28'd0, get_pins(4)}, 32'h0);
        check("abort_busy", {31'd0, get_busy(4)}, 32'h0);
        check("abort_res", {20'd0, get_res(4)}, {20'd0, 12'h00F});
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        m4 = 0;
        repeat (3) @(posedge clk);
        check("idle_after_abort", {31'd0, get_busy(4)}, 32'h0);
        pulse_start(4);
        run(4, -1, n, pp, py);
        check("post_abort_len", n, 120);
        check("post_abort_res", {20'd0, get_res(4)}, {20'd0, 12'h40F});

        // START during a run is ignored; START in DONE restarts and clears results
        m4 = 1;
        pulse_start(4);
        run(4, 30, n, pp, py);
        check("restart_ign_len", n, 120);
        check("restart_ign_err", {26'd0, if4.err_cnt}, 32'd20);
        m4 = 0;
        pulse_start(4);
        check("restart_res", {20'd0, get_res(4)}, {20'd0, 12'h00F});
        check("restart_busy", {31'd0, get_busy(4)}, 32'h1);
        run(4, -1, n, pp, py);
        check("restart_final", {20'd0, get_res(4)}, {20'd0, 12'h40F});

        // HOLD=3 with slow cells
        m3 = 3;
        pulse_start(3);
        run(3, -1, n, pp, py);
        check("h3_len", n, 90);
        check("h3_d1_res", {20'd0, get_res(3)}, {20'd0, 12'h40F});
        m3 = 4;
        pulse_start(3);
        run(3, -1, n, pp, py);
        check("h3_d2_res", {20'd0, get_res(3)}, {20'd0, 12'h400 | (12'd20 << 4) | 12'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
